ibex_dmem_adapter: RTL and testbench

IBEX_DMEM_ADAPTER -- requirements
Module: ibex_dmem_adapter

---
 rtl/ibex_dmem_adapter.sv | 182 ++++++++++++++++++
 tb/tb_ibex_dmem_adapter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_dmem_adapter.sv
// Ibex data-port to single-port SRAM adapter.
// Keeps a 2-deep in-order request FIFO. Out-of-window requests get an error
// response, and an SRAM that never answers produces a timeout error.
module ibex_dmem_adapter #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        sram_req,
    input  logic        sram_gnt,
    input  logic        sram_rvalid,
    output logic        sram_we,
    output logic [3:0]  sram_be,
    output logic [9:0]  sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, ERR, RESP} state_t;

    state_t state, state_nxt;

    logic        f_we    [2];
    logic [3:0]  f_be    [2];
    logic [9:0]  f_addr  [2];
    logic [31:0] f_wdata [2];
    logic        f_oor   [2];
    logic        wr_ptr, rd_ptr;
    logic [1:0]  count;
    logic        full, empty, push, pop;

    logic        h_we, h_oor;
    logic [3:0]  h_be;
    logic [9:0]  h_addr;
    logic [31:0] h_wdata;

    logic [CNT_W-1:0] cnt;
    logic [31:0]      cap_data;
    logic             err_q;
    logic             drive;

    // Byte offset bits are not needed for word addressing.
    logic unused_addr;
    assign unused_addr = ^data_addr_i[1:0];

    assign full       = (count == 2'd2);
    assign empty      = (count == 2'd0);
    assign data_gnt_o = data_req_i && !full;
    assign push       = data_req_i && data_gnt_o;
    assign pop        = (state == RESP);

    assign h_we    = f_we[rd_ptr];
    assign h_be    = f_be[rd_ptr];
    assign h_addr  = f_addr[rd_ptr];
    assign h_wdata = f_wdata[rd_ptr];
    assign h_oor   = f_oor[rd_ptr];

    // Request FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                f_we[i]    <= 1'b0;
                f_be[i]    <= 4'h0;
                f_addr[i]  <= 10'h000;
                f_wdata[i] <= 32'h0;
                f_oor[i]   <= 1'b0;
            end
        end else begin
            if (push) begin
                f_we[wr_ptr]    <= data_we_i;
                f_be[wr_ptr]    <= data_be_i;
                f_addr[wr_ptr]  <= data_addr_i[11:2];
                f_wdata[wr_ptr] <= data_wdata_i;
                f_oor[wr_ptr]   <= (data_addr_i[31:12] != BASE_ADDR[31:12]);
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (!empty) state_nxt = h_oor ? ERR : REQ;
            REQ:  if (sram_gnt) state_nxt = WAIT;
            WAIT: if (sram_rvalid || (cnt == CNT_W'(TIMEOUT - 1))) state_nxt = RESP;
            ERR:  state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Timeout counter, response data capture and error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            cap_data <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                REQ: begin
                    if (sram_gnt) cnt <= '0;
                end
                WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (sram_rvalid) begin
                        cap_data <= h_we ? 32'h0 : sram_rdata;
                        err_q    <= 1'b0;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        cap_data <= 32'h0;
                        err_q    <= 1'b1;
                    end
                end
                ERR: begin
                    cap_data <= 32'h0;
                    err_q    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Output decode from state; SRAM payload held from REQ through RESP.
    always_comb begin
        sram_req      = 1'b0;
        sram_we       = 1'b0;
        sram_be       = 4'h0;
        sram_addr     = 10'h000;
        sram_wdata    = 32'h0;
        data_rvalid_o = 1'b0;
        data_rdata_o  = 32'h0;
        data_err_o    = 1'b0;
        drive = (state == REQ) || (state == WAIT) || ((state == RESP) && !h_oor);
        if (drive) begin
            sram_we    = h_we;
            sram_be    = h_be;
            sram_addr  = h_addr;
            sram_wdata = h_wdata;
        end
        if (state == REQ) begin
            sram_req = 1'b1;
        end
        if (state == RESP) begin
            data_rvalid_o = 1'b1;
            data_rdata_o  = cap_data;
            data_err_o    = err_q;
        end
    end

endmodule

// File: tb/tb_ibex_dmem_adapter.sv
// Directed bench for ibex_dmem_adapter: table of single transactions plus
// hand-written back-to-back, timeout and reset-in-WAIT sequences.
module tb_ibex_dmem_adapter;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_req_i, data_gnt_o, data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i, data_wdata_i;
    logic        data_rvalid_o, data_err_o;
    logic [31:0] data_rdata_o;
    logic        sram_req, sram_gnt, sram_rvalid, sram_we;
    logic [3:0]  sram_be;
    logic [9:0]  sram_addr;
    logic [31:0] sram_wdata, sram_rdata;

    ibex_dmem_adapter #(.BASE_ADDR(32'h0000_0000), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_we_i(data_we_i),
        .data_be_i(data_be_i), .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .sram_req(sram_req), .sram_gnt(sram_gnt), .sram_rvalid(sram_rvalid),
        .sram_we(sram_we), .sram_be(sram_be), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Memory model configuration and observations.
    int          gnt_dly = 0, rv_dly = 1;
    bit          mem_never = 1'b0;
    logic [31:0] mem_seed = 32'h0;
    bit          pending = 1'b0, stale = 1'b0;
    int          rv_left = 0, req_run = 0, req_cycles_last = 0;
    int          n_grants = 0, n_req_cycles = 0, req_after = 0, hold_bad = 0;
    int          g_cyc = 0, rv_cyc = 0;
    logic [9:0]  g_addr = 10'h0;
    logic        g_we = 1'b0;
    logic [3:0]  g_be = 4'h0;
    logic [31:0] g_wdata = 32'h0;

    // SRAM model: grants after gnt_dly extra req cycles, answers rv_dly cycles after grant.
    initial begin
        sram_gnt = 1'b0; sram_rvalid = 1'b0; sram_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            sram_gnt = 1'b0; sram_rvalid = 1'b0; sram_rdata = 32'h0;
            if (rst) stale = 1'b1;
            if (sram_req) n_req_cycles++;
            if (pending) begin
                if (sram_req) req_after++;
                if (!stale && sram_addr != g_addr) hold_bad++;
                rv_left--;
                if (rv_left <= 0) begin
                    sram_rvalid = 1'b1;
                    sram_rdata  = mem_seed ^ {22'h0, g_addr};
                    rv_cyc      = cyc;
                    pending     = 1'b0;
                    stale       = 1'b0;
                end
            end else if (sram_req) begin
                req_run++;
                if (req_run > gnt_dly) begin
                    sram_gnt = 1'b1;
                    g_addr = sram_addr; g_we = sram_we; g_be = sram_be; g_wdata = sram_wdata;
                    g_cyc = cyc;
                    n_grants++;
                    req_cycles_last = req_run;
                    req_run = 0;
                    if (!mem_never) begin
                        pending = 1'b1;
                        rv_left = rv_dly;
                    end
                end
            end
        end
    end

    typedef struct {
        logic [31:0] rd;
        logic        er;
        int          c;
    } resp_t;
    resp_t resp_q[$];
    int    idle_bad = 0;

    // Response monitor.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (data_rvalid_o) begin
                resp_t r;
                r.rd = data_rdata_o; r.er = data_err_o; r.c = cyc;
                resp_q.push_back(r);
            end else if (data_rdata_o != 32'h0 || data_err_o) begin
                idle_bad++;
            end
        end
    end

    task automatic wait_resp(output resp_t r, output bit ok);
        ok = 1'b0;
        r.rd = 32'h0; r.er = 1'b0; r.c = 0;
        for (int i = 0; i < 80; i++) begin
            if (resp_q.size() > 0) begin
                r  = resp_q.pop_front();
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL resp_timeout: got none want response (cycle %0d)", cyc);
        end
    endtask

    // Present one request that must be granted in the same cycle.
    task automatic issue(input logic we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wdata, output int gc);
        data_req_i = 1'b1; data_we_i = we; data_be_i = be;
        data_addr_i = addr; data_wdata_i = wdata;
        #1;
        chk("gnt_immediate", 32'(data_gnt_o), 32'h1);
        gc = cyc;
        tick();
        data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = 4'h0;
        data_addr_i = 32'h0; data_wdata_i = 32'h0;
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] seed;
        int          gd;
        int          rd;
        logic [9:0]  exp_saddr;
        logic        oor;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t  vt[6];
    resp_t r;
    bit    ok;
    int    gc, gc2, ng0, nr0, hb0, ra0, ga, rv_at, gn_at;
    logic [31:0] b2b_exp[3];

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        vt[0] = '{1'b0, 4'hF, 32'h0000_0010, 32'h0, 32'hDEAD_BEEB, 1, 2, 10'h004, 1'b0, 32'hDEAD_BEEF, 1'b0};
        vt[1] = '{1'b1, 4'h3, 32'h0000_0FFC, 32'h1234_5678, 32'hFFFF_FFFF, 0, 1, 10'h3FF, 1'b0, 32'h0, 1'b0};
        vt[2] = '{1'b0, 4'hF, 32'h0000_1000, 32'h0, 32'h0, 0, 1, 10'h000, 1'b1, 32'h0, 1'b1};
        vt[3] = '{1'b0, 4'h1, 32'h0000_0ABC, 32'h0, 32'h0, 3, 1, 10'h2AF, 1'b0, 32'h0000_02AF, 1'b0};
        vt[4] = '{1'b0, 4'hF, 32'hFFFF_F000, 32'h0, 32'h0, 0, 1, 10'h000, 1'b1, 32'h0, 1'b1};
        vt[5] = '{1'b1, 4'hC, 32'h0000_07F0, 32'hA5A5_0F0F, 32'h1111_1111, 2, 4, 10'h1FC, 1'b0, 32'h0, 1'b0};
        b2b_exp[0] = 32'h5000_0040;
        b2b_exp[1] = 32'h5000_0041;
        b2b_exp[2] = 32'h5000_0042;

        rst = 1'b1;
        data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = 4'h0;
        data_addr_i = 32'h0; data_wdata_i = 32'h0;
        repeat (3) tick();

        // Reset state: outputs quiet, grant follows request.
        chk("rst_outs_zero", 32'(|{sram_req, sram_we, sram_be, sram_addr, sram_wdata,
                                   data_rvalid_o, data_rdata_o, data_err_o}), 32'h0);
        data_req_i = 1'b1; #1;
        chk("rst_gnt_follows_req1", 32'(data_gnt_o), 32'h1);
        data_req_i = 1'b0; #1;
        chk("rst_gnt_follows_req0", 32'(data_gnt_o), 32'h0);
        rst = 1'b0;
        tick();
        tick();

        // Single transactions from the table.
        for (int i = 0; i < 6; i++) begin
            gnt_dly = vt[i].gd; rv_dly = vt[i].rd; mem_seed = vt[i].seed; mem_never = 1'b0;
            ng0 = n_grants; nr0 = n_req_cycles; hb0 = hold_bad; ra0 = req_after;
            issue(vt[i].we, vt[i].be, vt[i].addr, vt[i].wdata, gc);
            wait_resp(r, ok);
            if (ok) begin
                chk($sformatf("v%0d_rdata", i), r.rd, vt[i].exp_rdata);
                chk($sformatf("v%0d_err", i), 32'(r.er), 32'(vt[i].exp_err));
            end
            if (vt[i].oor) begin
                chk($sformatf("v%0d_no_grant", i), 32'(n_grants - ng0), 32'h0);
                chk($sformatf("v%0d_no_sram_req", i), 32'(n_req_cycles - nr0), 32'h0);
                if (ok) chk($sformatf("v%0d_oor_latency", i), 32'(r.c - gc), 32'd3);
            end else begin
                chk($sformatf("v%0d_sram_addr", i), 32'(g_addr), 32'(vt[i].exp_saddr));
                chk($sformatf("v%0d_sram_we", i), 32'(g_we), 32'(vt[i].we));
                chk($sformatf("v%0d_sram_be", i), 32'(g_be), 32'(vt[i].be));
                chk($sformatf("v%0d_sram_wdata", i), g_wdata, vt[i].wdata);
                chk($sformatf("v%0d_req_cycles", i), 32'(req_cycles_last), 32'(vt[i].gd + 1));
                chk($sformatf("v%0d_req_after_gnt", i), 32'(req_after - ra0), 32'h0);
                chk($sformatf("v%0d_addr_hold", i), 32'(hold_bad - hb0), 32'h0);
                if (ok) chk($sformatf("v%0d_rv_latency", i), 32'(r.c - rv_cyc), 32'h1);
            end
            tick();
            tick();
        end

        // Back-to-back: third request held until the first response has popped.
        gnt_dly = 1; rv_dly = 2; mem_seed = 32'h5000_0000; mem_never = 1'b0;
        issue(1'b0, 4'hF, 32'h0000_0100, 32'h0, gc);
        issue(1'b0, 4'hF, 32'h0000_0104, 32'h0, gc);
        data_req_i = 1'b1; data_we_i = 1'b0; data_be_i = 4'hF; data_addr_i = 32'h0000_0108;
        #1;
        chk("b2b_third_held", 32'(data_gnt_o), 32'h0);
        rv_at = -1; gn_at = -1;
        for (int i = 0; i < 40; i++) begin
            if (data_rvalid_o && rv_at < 0) rv_at = cyc;
            if (data_gnt_o) begin
                gn_at = cyc;
                break;
            end
            tick();
            #1;
        end
        chk("b2b_resp_seen", 32'(rv_at >= 0), 32'h1);
        chk("b2b_gnt_after_resp", 32'(gn_at - rv_at), 32'h1);
        tick();
        data_req_i = 1'b0; data_be_i = 4'h0; data_addr_i = 32'h0;
        for (int i = 0; i < 3; i++) begin
            wait_resp(r, ok);
            if (ok) begin
                chk($sformatf("b2b_rdata%0d", i), r.rd, b2b_exp[i]);
                chk($sformatf("b2b_err%0d", i), 32'(r.er), 32'h0);
            end
        end
        tick();
        tick();

        // Timeout: SRAM never answers, queued request proceeds afterwards.
        gnt_dly = 0; rv_dly = 1; mem_never = 1'b1; mem_seed = 32'h7700_0000;
        ng0 = n_grants;
        issue(1'b0, 4'hF, 32'h0000_0020, 32'h0, gc);
        issue(1'b0, 4'hF, 32'h0000_0024, 32'h0, gc2);
        for (int i = 0; i < 20 && n_grants == ng0; i++) tick();
        chk("to_granted", 32'(n_grants - ng0), 32'h1);
        ga = g_cyc;
        mem_never = 1'b0;
        wait_resp(r, ok);
        if (ok) begin
            chk("to_err", 32'(r.er), 32'h1);
            chk("to_rdata", r.rd, 32'h0);
            chk("to_latency", 32'(r.c - ga), 32'd17);
        end
        wait_resp(r, ok);
        if (ok) begin
            chk("to_next_rdata", r.rd, 32'h7700_0009);
            chk("to_next_err", 32'(r.er), 32'h0);
        end
        tick();
        tick();

        // Reset pulsed during WAIT; the late rvalid must be ignored.
        gnt_dly = 0; rv_dly = 5; mem_seed = 32'h0; mem_never = 1'b0;
        ng0 = n_grants;
        issue(1'b0, 4'hF, 32'h0000_0040, 32'h0, gc);
        for (int i = 0; i < 20 && n_grants == ng0; i++) tick();
        chk("rw_granted", 32'(n_grants - ng0), 32'h1);
        tick();
        tick();
        #1;
        rst = 1'b1;
        #1;
        chk("rw_outs_zero", 32'(|{sram_req, sram_we, sram_be, sram_addr, sram_wdata,
                                  data_rvalid_o, data_rdata_o, data_err_o}), 32'h0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #2;
        repeat (4) tick();
        chk("rw_no_resp", 32'(resp_q.size()), 32'h0);
        hb0 = hold_bad;
        rv_dly = 2; mem_seed = 32'hCAFE_0000;
        issue(1'b0, 4'hF, 32'h0000_0044, 32'h0, gc);
        wait_resp(r, ok);
        if (ok) begin
            chk("rw_after_rdata", r.rd, 32'hCAFE_0011);
            chk("rw_after_err", 32'(r.er), 32'h0);
            chk("rw_after_latency", 32'(r.c - rv_cyc), 32'h1);
        end
        chk("rw_after_hold", 32'(hold_bad - hb0), 32'h0);
        tick();
        tick();

        chk("quiet_outside_resp", 32'(idle_bad), 32'h0);
        chk("req_after_gnt_total", 32'(req_after), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
